traffic_source: RTL and testbench
=================================

// Module: traffic_source
// PURPOSE
// - Per-router packet injector for the NoC simulator; one instance per router node.
// - The top-level scheduler configures it, then fills it with packet descriptors (dst, vc, flit count).
// - It presents one flit at a time on `buffer` for injection into router inport 0.
// - It advances on Dequeue and asserts `done` once every configured packet's tail flit has left.
// PARAMETERS
// DEPTH    16   descriptor FIFO entries (power of 2)
// DST_W    14   destination router id width
// VC_W     4    virtual channel id width
// NF_W     10   flits-per-packet width
// CNT_W    10   total-packet counter width
// DATA_W   32   op data bus width
// OP_W     4    op code width
// PORTS
// clk     in   1                 clock, all state on rising edge
// rst_n   in   1                 asynchronous active-low reset
// op      in   OP_W              0=NOP 5=Init 6=Fill 7=Dequeue 8=PreDeque; any other code = NOP
// data    in   DATA_W            Init: [31:22]=total packets; Fill: [13:0]=dst, [17:14]=vc, [27:18]=num flits
// done    out  1                 all configured packets fully dequeued
// buffer  out  3+VC_W+DST_W      current flit: [0]=full [1]=head [2]=tail [6:3]=vc [20:7]=dst
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty, buffer=0, done=0, total=0, sent=0, remaining=0.
// - All ops are sampled on the rising clk edge. Outputs are registered and change on that same edge (1-cycle latency).
// - Init:
//   - rd/wr pointers <= 0; total <= data[31:22]; sent <= 0; buffer <= 0; done <= 0.
// - Fill:
//   - If FIFO not full, push {dst, vc, nf}; if nf==0 it is stored as 1.
//   - If FIFO is full, the descriptor is discarded and state is unchanged.
// - "Load" action (pop head descriptor, if FIFO non-empty):
//   - buffer <= {dst, vc, tail=(nf==1), head=1, full=1}; remaining <= nf-1.
//   - If FIFO is empty: buffer <= 0.
// - PreDeque:
//   - If buffer.full==0, perform Load; otherwise no change.
// - Dequeue, with buffer.full==0:
//   - Perform Load. Must be harmless: the scheduler issues Dequeue based on router credit, even when empty.
// - Dequeue, with buffer.full==1 and tail==0:
//   - head <= 0; tail <= (remaining==1); remaining <= remaining-1; dst and vc unchanged.
// - Dequeue, with buffer.full==1 and tail==1:
//   - sent <= sent+1, then Load in the same cycle (back-to-back packets, no bubble).
// - done <= (sent == total) && buffer.full==0 && FIFO empty.
//   - Recomputed every cycle after the first Init; stays 0 before any Init.
//   - Init with total=0 yields done=1 one cycle after Init.
// - Counters: sent saturates at its max and never wraps; FIFO pointers wrap modulo DEPTH with a separate count/full flag.
// - Simultaneous events are impossible (single op bus); NOP holds all state.
// - Reset mid-operation discards queued and in-flight flits immediately.
// TESTING
// - Reset, then Init total=0 -> done=1 on the 2nd edge; buffer=0.
// - Init 2; Fill{dst=3,vc=1,nf=1}; Fill{dst=5,vc=0,nf=3}; PreDeque
//   -> buffer full=1 head=1 tail=1 vc=1 dst=3.
//   - Dequeue -> head of pkt2 (dst=5, tail=0).
//   - Dequeue x2 -> body (head=0, tail=0), then tail (tail=1).
//   - Dequeue -> buffer=0, done=1.
// - Dequeue with empty FIFO and empty buffer -> buffer stays 0, no counter change, done unaffected.
// - Fill DEPTH+1 descriptors -> last descriptor dropped; exactly DEPTH packets emitted in order.
// - Fill{nf=0} -> emitted as a single flit with head=1 and tail=1.
// - Assert rst_n=0 while mid-packet (remaining=2) -> buffer=0 and done=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/traffic_source.sv
// ---------------------------------------------------------------------------
// traffic_source
//   Per-router packet injector. The scheduler sets the expected packet count
//   with Init and queues packet descriptors with Fill. The block then presents
//   one flit at a time on `buffer` and steps through it on Dequeue/PreDeque.
//   `done` rises once every configured packet's tail flit has left.
//
// Ports
//   clk     in   1            clock; all state changes on the rising edge
//   rst_n   in   1            asynchronous active-low reset
//   op      in   OP_W         0=NOP 5=Init 6=Fill 7=Dequeue 8=PreDeque (others=NOP)
//   data    in   DATA_W       Init: [31:22]=total packets
//                             Fill: [13:0]=dst [17:14]=vc [27:18]=num flits
//   done    out  1            all configured packets fully dequeued
//   buffer  out  3+VC_W+DST_W current flit {dst, vc, tail, head, full}
// ---------------------------------------------------------------------------
module traffic_source #(
  parameter int DEPTH  = 16,
  parameter int DST_W  = 14,
  parameter int VC_W   = 4,
  parameter int NF_W   = 10,
  parameter int CNT_W  = 10,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OP_W-1:0]           op,
  input  logic [DATA_W-1:0]         data,
  output logic                      done,
  output logic [2+VC_W+DST_W:0]     buffer
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DESC_W = DST_W + VC_W + NF_W;
  localparam int BUF_W  = 3 + VC_W + DST_W;

  localparam logic [OP_W-1:0]  OP_INIT  = OP_W'(5);
  localparam logic [OP_W-1:0]  OP_FILL  = OP_W'(6);
  localparam logic [OP_W-1:0]  OP_DEQ   = OP_W'(7);
  localparam logic [OP_W-1:0]  OP_PREDQ = OP_W'(8);
  localparam logic [CNT_W-1:0] SENT_MAX = '1;
  localparam logic [AW:0]      FIFO_CAP = (AW+1)'(DEPTH);

  // Descriptor storage: {dst, vc, nf}, nf in the low bits.
  logic [DESC_W-1:0] mem [DEPTH];

  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] total, sent;
  logic [NF_W-1:0]  remaining;
  logic             inited;

  logic [AW-1:0]    n_rd_ptr, n_wr_ptr;
  logic [AW:0]      n_count;
  logic [CNT_W-1:0] n_total, n_sent;
  logic [NF_W-1:0]  n_remaining;
  logic             n_inited, n_done;
  logic [BUF_W-1:0] n_buffer;

  logic push, pop, load, advance, retire;
  logic fifo_empty, fifo_full;

  logic [DST_W-1:0]  fill_dst;
  logic [VC_W-1:0]   fill_vc;
  logic [NF_W-1:0]   fill_nf;
  logic [DESC_W-1:0] head_desc;
  logic [DST_W-1:0]  hd_dst;
  logic [VC_W-1:0]   hd_vc;
  logic [NF_W-1:0]   hd_nf;

  assign fill_dst = data[DST_W-1:0];
  assign fill_vc  = data[DST_W+VC_W-1:DST_W];
  assign fill_nf  = data[DESC_W-1:DST_W+VC_W];

  assign head_desc = mem[rd_ptr];
  assign hd_nf     = head_desc[NF_W-1:0];
  assign hd_vc     = head_desc[NF_W+VC_W-1:NF_W];
  assign hd_dst    = head_desc[DESC_W-1:NF_W+VC_W];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_CAP);

  always_comb begin
    push        = 1'b0;
    load        = 1'b0;
    advance     = 1'b0;
    retire      = 1'b0;
    n_rd_ptr    = rd_ptr;
    n_wr_ptr    = wr_ptr;
    n_count     = count;
    n_total     = total;
    n_sent      = sent;
    n_remaining = remaining;
    n_inited    = inited;
    n_buffer    = buffer;

    case (op)
      OP_FILL:  push = !fifo_full;
      OP_PREDQ: load = !buffer[0];
      OP_DEQ: begin
        // An empty buffer just tries a Load, so credit-driven Dequeues on an
        // idle source are harmless. A tail flit retires the packet and loads
        // the next one in the same cycle, leaving no bubble.
        if (!buffer[0])      load    = 1'b1;
        else if (!buffer[2]) advance = 1'b1;
        else begin
          retire = 1'b1;
          load   = 1'b1;
        end
      end
      default: ;
    endcase

    pop = load && !fifo_empty;

    // push and pop come from different ops, so they never happen together.
    if (push) begin
      n_wr_ptr = wr_ptr + 1'b1;
      n_count  = count + 1'b1;
    end
    if (pop) begin
      n_rd_ptr = rd_ptr + 1'b1;
      n_count  = count - 1'b1;
    end

    if (retire && (sent != SENT_MAX)) n_sent = sent + 1'b1;

    if (load) begin
      if (pop) begin
        n_buffer    = {hd_dst, hd_vc, (hd_nf == NF_W'(1)), 1'b1, 1'b1};
        n_remaining = hd_nf - 1'b1;
      end else begin
        n_buffer    = '0;
        n_remaining = '0;
      end
    end

    if (advance) begin
      n_buffer[1] = 1'b0;
      n_buffer[2] = (remaining == NF_W'(1));
      n_remaining = remaining - 1'b1;
    end

    if (op == OP_INIT) begin
      n_rd_ptr    = '0;
      n_wr_ptr    = '0;
      n_count     = '0;
      n_total     = data[DATA_W-1 -: CNT_W];
      n_sent      = '0;
      n_remaining = '0;
      n_buffer    = '0;
      n_inited    = 1'b1;
    end

    // done reflects the state being written this edge; Init forces it low
    // so that total=0 shows done one cycle after the Init.
    n_done = n_inited && (n_sent == n_total) && !n_buffer[0] && (n_count == '0);
    if (op == OP_INIT) n_done = 1'b0;
  end

  // Descriptor memory holds data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fill_dst, fill_vc, (fill_nf == '0) ? NF_W'(1) : fill_nf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      total     <= '0;
      sent      <= '0;
      remaining <= '0;
      inited    <= 1'b0;
      buffer    <= '0;
      done      <= 1'b0;
    end else begin
      rd_ptr    <= n_rd_ptr;
      wr_ptr    <= n_wr_ptr;
      count     <= n_count;
      total     <= n_total;
      sent      <= n_sent;
      remaining <= n_remaining;
      inited    <= n_inited;
      buffer    <= n_buffer;
      done      <= n_done;
    end
  end

endmodule

// File: tb/tb_traffic_source.sv
module tb_traffic_source;

  localparam int BW    = 21;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic [3:0]    op;
  logic [31:0]   data;
  logic          done;
  logic [BW-1:0] buffer;

  traffic_source dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .op     (op),
    .data   (data),
    .done   (done),
    .buffer (buffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: descriptors wait in a queue; the current packet is
  // expanded into its full list of flit words, and the visible flit is the
  // front of that list.
  typedef struct packed {
    logic [13:0] dst;
    logic [3:0]  vc;
    logic [9:0]  nf;
  } desc_t;

  desc_t         m_fifo[$];
  logic [BW-1:0] m_flits[$];
  int            m_total;
  int            m_sent;
  bit            m_inited;
  bit            m_done;

  task automatic model_reset();
    m_fifo.delete();
    m_flits.delete();
    m_total  = 0;
    m_sent   = 0;
    m_inited = 0;
    m_done   = 0;
  endtask

  task automatic model_load();
    desc_t d;
    if (m_fifo.size() > 0) begin
      d = m_fifo.pop_front();
      for (int k = 0; k < int'(d.nf); k++)
        m_flits.push_back({d.dst, d.vc, (k == int'(d.nf) - 1), (k == 0), 1'b1});
    end
  endtask

  task automatic model_step(input logic [3:0] o, input logic [31:0] d);
    desc_t        nd;
    logic [BW-1:0] f;
    case (o)
      4'd5: begin
        m_fifo.delete();
        m_flits.delete();
        m_total  = int'(d[31:22]);
        m_sent   = 0;
        m_inited = 1;
      end
      4'd6: begin
        if (m_fifo.size() < DEPTH) begin
          nd.dst = d[13:0];
          nd.vc  = d[17:14];
          nd.nf  = (d[27:18] == 10'd0) ? 10'd1 : d[27:18];
          m_fifo.push_back(nd);
        end
      end
      4'd7: begin
        if (m_flits.size() == 0) model_load();
        else begin
          f = m_flits.pop_front();
          if (f[2]) begin
            if (m_sent < 1023) m_sent++;
            model_load();
          end
        end
      end
      4'd8: if (m_flits.size() == 0) model_load();
      default: ;
    endcase
    m_done = m_inited && (m_sent == m_total) && (m_flits.size() == 0) && (m_fifo.size() == 0);
    if (o == 4'd5) m_done = 0;
  endtask

  function automatic logic [BW-1:0] exp_buf();
    return (m_flits.size() > 0) ? m_flits[0] : '0;
  endfunction

  // Cycle-by-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_cmp++;
        if (buffer !== exp_buf() || done !== m_done) begin
          n_bad++;
          $display("FAIL cycle_chk t=%0t buffer=%h exp=%h done=%b exp=%b",
                   $time, buffer, exp_buf(), done, m_done);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] d);
    @(negedge clk);
    op   = o;
    data = d;
    @(posedge clk);
    model_step(o, d);
    #1;
    op   = 4'd0;
    data = '0;
  endtask

  function automatic logic [31:0] fd(input int dst, input int vc, input int nf);
    return ((32'(nf) & 32'h3FF) << 18) | ((32'(vc) & 32'hF) << 14) | (32'(dst) & 32'h3FFF);
  endfunction

  initial begin
    int r, t;
    logic [3:0]  ro;
    logic [31:0] rd;

    op    = 4'd0;
    data  = '0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_buffer", 32'(buffer), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Init with zero packets: done appears on the second edge.
    do_op(4'd5, 32'd0);
    chk("init0_done_first_edge", 32'(done), 32'd0);
    do_op(4'd0, 32'd0);
    chk("init0_done_second_edge", 32'(done), 32'd1);
    chk("init0_buffer", 32'(buffer), 32'd0);

    // Two packets: single-flit then three-flit.
    do_op(4'd5, 32'h0080_0000);
    do_op(4'd6, fd(3, 1, 1));
    do_op(4'd6, fd(5, 0, 3));
    do_op(4'd8, 32'd0);
    chk("pkt1_single", 32'(buffer), 32'd399);
    chk("pkt1_done", 32'(done), 32'd0);
    do_op(4'd7, 32'd0);
    chk("pkt2_head", 32'(buffer), 32'd643);
    do_op(4'd7, 32'd0);
    chk("pkt2_body", 32'(buffer), 32'd641);
    do_op(4'd7, 32'd0);
    chk("pkt2_tail", 32'(buffer), 32'd645);
    do_op(4'd7, 32'd0);
    chk("pkts_drained_buffer", 32'(buffer), 32'd0);
    chk("pkts_drained_done", 32'(done), 32'd1);

    // Dequeue while idle.
    do_op(4'd7, 32'd0);
    chk("idle_deq_buffer", 32'(buffer), 32'd0);
    chk("idle_deq_done", 32'(done), 32'd1);

    // Overfill: the 17th descriptor is dropped.
    do_op(4'd5, 32'd16 << 22);
    for (int i = 0; i <= DEPTH; i++) do_op(4'd6, fd(100 + i, i, 1));
    do_op(4'd8, 32'd0);
    chk("ovf_first_dst", 32'(buffer[20:7]), 32'd100);
    for (int i = 1; i < DEPTH; i++) begin
      do_op(4'd7, 32'd0);
      chk("ovf_order_dst", 32'(buffer[20:7]), 32'(100 + i));
    end
    do_op(4'd7, 32'd0);
    chk("ovf_end_buffer", 32'(buffer), 32'd0);
    chk("ovf_end_done", 32'(done), 32'd1);

    // nf=0 is treated as a single flit.
    do_op(4'd5, 32'h0040_0000);
    do_op(4'd6, fd(9, 2, 0));
    do_op(4'd8, 32'd0);
    chk("nf0_flit", 32'(buffer), 32'd1175);
    do_op(4'd7, 32'd0);
    chk("nf0_done", 32'(done), 32'd1);

    // Asynchronous reset in the middle of a three-flit packet.
    do_op(4'd5, 32'h0040_0000);
    do_op(4'd6, fd(7, 3, 3));
    do_op(4'd8, 32'd0);
    chk("mid_pkt_head", 32'(buffer), 32'd923);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_buffer", 32'(buffer), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, starting un-initialised.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        t  = $urandom_range(0, 6);
        ro = 4'd5;
        rd = (32'(t) << 22) | ($urandom & 32'h003F_FFFF);
      end else if (r < 40) begin
        ro = 4'd6;
        rd = fd($urandom, $urandom, $urandom_range(0, 4)) | ($urandom & 32'hF000_0000);
      end else if (r < 75) begin
        ro = 4'd7;
        rd = $urandom;
      end else if (r < 85) begin
        ro = 4'd8;
        rd = $urandom;
      end else if (r < 92) begin
        ro = 4'd0;
        rd = $urandom;
      end else begin
        t  = $urandom_range(0, 10);
        ro = (t < 4) ? 4'(t + 1) : 4'(t + 5);
        rd = $urandom;
      end
      do_op(ro, rd);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
